// File: rtl/maxunpool_nbit_kdim_kcc_if.sv
// Handshake bundle for the serial max-unpool stage: descriptor input side,
// element output side and the sticky index-error flag.
interface maxunpool_nbit_kdim_kcc_if #(
   parameter int N = 8,
   parameter int K = 2
);
   localparam int IW = $clog2(K*K);

   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in_max;
   logic [IW-1:0] in_idx;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  out_data;
   logic          out_last;
   logic          idx_err;

   modport master (
      output in_valid, in_max, in_idx, out_ready,
      input  in_ready, out_valid, out_data, out_last, idx_err
   );

   modport slave (
      input  in_valid, in_max, in_idx, out_ready,
      output in_ready, out_valid, out_data, out_last, idx_err
   );
endinterface

// File: rtl/maxunpool_nbit_kdim_kcc.sv
// Serial max-unpool: expands one pooled value + argmax index into K*K beats.
// Define MAXUNPOOL_B2B_EN to accept the next descriptor on the last beat (no bubble).
module maxunpool_nbit_kdim_kcc #(
   parameter int N = 8,
   parameter int K = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   maxunpool_nbit_kdim_kcc_if.slave  bus
);
   localparam int KK = K*K;
   localparam int IW = $clog2(KK);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t        state, state_d;
   logic [IW-1:0] cnt, cnt_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [N-1:0]  max_q, max_d;
   logic          err_q, err_d;
   logic          last;
   logic          accept;
   logic          idx_oob;

   assign last          = (state == EMIT) && (cnt == IW'(KK-1));
   assign bus.out_valid = (state == EMIT);
   assign bus.out_last  = last;
   assign bus.out_data  = ((state == EMIT) && (cnt == idx_q)) ? max_q : '0;
   assign bus.idx_err   = err_q;

`ifdef MAXUNPOOL_B2B_EN
   assign bus.in_ready  = (state == IDLE) || (last && bus.out_ready);
`else
   assign bus.in_ready  = (state == IDLE);
`endif

   assign accept  = bus.in_valid && bus.in_ready;
   // Full-width compare: an index past K*K-1 must never alias onto a real element.
   assign idx_oob = {1'b0, bus.in_idx} >= (IW+1)'(KK);

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      idx_d   = idx_q;
      max_d   = max_q;
      err_d   = err_q;
      case (state)
         IDLE: begin
            if (accept) begin
               state_d = EMIT;
               cnt_d   = '0;
            end
         end
         EMIT: begin
            if (bus.out_ready) begin
               if (!last) begin
                  cnt_d = cnt + IW'(1);
               end else begin
                  cnt_d   = '0;
                  state_d = accept ? EMIT : IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (accept) begin
         max_d = bus.in_max;
         idx_d = bus.in_idx;
         if (idx_oob) err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         idx_q <= '0;
         max_q <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         idx_q <= idx_d;
         max_q <= max_d;
         err_q <= err_d;
      end
   end
endmodule
